// File: rtl/mac_operand_seq.sv
// mac_operand_seq: holds two DIM x DIM signed matrices A and B and, on a
// start request, streams the operand pairs of C = A*B to a downstream MAC,
// one term per cycle, with accumulator-clear and result-valid markers.
module mac_operand_seq #(
  parameter int DIM   = 4,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          load_en,
  input  logic                          load_sel,
  input  logic [$clog2(DIM*DIM)-1:0]    load_addr,
  input  logic signed [WIDTH-1:0]       load_data,
  input  logic                          start,
  output logic                          busy,
  output logic signed [WIDTH-1:0]       mplier,
  output logic signed [WIDTH-1:0]       mcand,
  output logic                          mac_clr,
  output logic                          res_valid,
  output logic [$clog2(DIM)-1:0]        res_row,
  output logic [$clog2(DIM)-1:0]        res_col,
  output logic                          done
);

  localparam int IW = $clog2(DIM);
  localparam int AW = $clog2(DIM*DIM);
  localparam logic [IW-1:0] LAST = IW'(DIM-1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  // Loop indices of the term currently on the outputs: i row, j column, k inner.
  logic [IW-1:0] i_idx, j_idx, k_idx;
  logic [IW-1:0] nxt_i, nxt_j, nxt_k;

  logic signed [WIDTH-1:0] a_mem [DIM*DIM];
  logic signed [WIDTH-1:0] b_mem [DIM*DIM];

  logic [AW-1:0]           a_rd, b_rd;
  logic signed [WIDTH-1:0] a_val, b_val;
  logic                    last_term;
  logic                    write_ok;

  // Writes are only honoured in IDLE so a running stream never sees its data move.
  assign write_ok  = aclr && (state == IDLE) && load_en;
  assign last_term = (i_idx == LAST) && (j_idx == LAST) && (k_idx == LAST);

  // Index of the term to present next: restarts at zero from IDLE, otherwise
  // advances k fastest, carrying into j and then i.
  always_comb begin
    nxt_i = i_idx;
    nxt_j = j_idx;
    nxt_k = k_idx;
    if (state == IDLE) begin
      nxt_i = '0;
      nxt_j = '0;
      nxt_k = '0;
    end else if (k_idx == LAST) begin
      nxt_k = '0;
      if (j_idx == LAST) begin
        nxt_j = '0;
        nxt_i = i_idx + ONE;
      end else begin
        nxt_j = j_idx + ONE;
      end
    end else begin
      nxt_k = k_idx + ONE;
    end
  end

  // Operand fetch for the next term; a write landing in the same cycle as
  // start is forwarded so the first term already carries the new value.
  always_comb begin
    a_rd  = {nxt_i, nxt_k};
    b_rd  = {nxt_k, nxt_j};
    a_val = a_mem[a_rd];
    b_val = b_mem[b_rd];
    if (write_ok && !load_sel && (load_addr == a_rd)) begin
      a_val = load_data;
    end
    if (write_ok && load_sel && (load_addr == b_rd)) begin
      b_val = load_data;
    end
  end

  // Matrix storage; contents deliberately survive reset untouched.
  always_ff @(posedge clk) begin
    if (write_ok) begin
      if (load_sel) begin
        b_mem[load_addr] <= load_data;
      end else begin
        a_mem[load_addr] <= load_data;
      end
    end
  end

  // Sequencer: IDLE waits for start, RUN emits one term per cycle, DRAIN
  // carries the final result marker and the done pulse.
  always_ff @(posedge clk) begin
    if (!aclr) begin
      state     <= IDLE;
      i_idx     <= '0;
      j_idx     <= '0;
      k_idx     <= '0;
      busy      <= 1'b0;
      mplier    <= '0;
      mcand     <= '0;
      mac_clr   <= 1'b1;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_col   <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          done      <= 1'b0;
          mac_clr   <= 1'b1;
          i_idx     <= '0;
          j_idx     <= '0;
          k_idx     <= '0;
          if (start) begin
            state  <= RUN;
            busy   <= 1'b1;
            mplier <= a_val;
            mcand  <= b_val;
          end else begin
            busy   <= 1'b0;
            mplier <= '0;
            mcand  <= '0;
          end
        end

        RUN: begin
          res_valid <= (k_idx == LAST);
          if (k_idx == LAST) begin
            res_row <= i_idx;
            res_col <= j_idx;
          end
          if (last_term) begin
            state   <= DRAIN;
            done    <= 1'b1;
            mplier  <= '0;
            mcand   <= '0;
            mac_clr <= 1'b1;
            i_idx   <= '0;
            j_idx   <= '0;
            k_idx   <= '0;
          end else begin
            i_idx   <= nxt_i;
            j_idx   <= nxt_j;
            k_idx   <= nxt_k;
            mplier  <= a_val;
            mcand   <= b_val;
            mac_clr <= (nxt_k == '0);
          end
        end

        DRAIN: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
          mplier    <= '0;
          mcand     <= '0;
          mac_clr   <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          done      <= 1'b0;
          mplier    <= '0;
          mcand     <= '0;
          mac_clr   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_seq.sv
// tb_mac_operand_seq: directed and randomized runs of mac_operand_seq checked
// cycle by cycle against a matrix-level reference model and a reference MAC.
module tb_mac_operand_seq;

  localparam int DIM   = 4;
  localparam int WIDTH = 8;

  logic              clk = 1'b0;
  logic              aclr;
  logic              load_en;
  logic              load_sel;
  logic [3:0]        load_addr;
  logic signed [7:0] load_data;
  logic              start;
  logic              busy;
  logic signed [7:0] mplier;
  logic signed [7:0] mcand;
  logic              mac_clr;
  logic              res_valid;
  logic [1:0]        res_row;
  logic [1:0]        res_col;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int run_start   = -1;
  int ref_a [16];
  int ref_b [16];
  int acc         = 0;

  always #5 clk = ~clk;

  mac_operand_seq #(.DIM(DIM), .WIDTH(WIDTH)) dut (
    .clk(clk), .aclr(aclr), .load_en(load_en), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data), .start(start),
    .busy(busy), .mplier(mplier), .mcand(mcand), .mac_clr(mac_clr),
    .res_valid(res_valid), .res_row(res_row), .res_col(res_col), .done(done)
  );

  // One comparison point.
  task automatic checkOutput(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s at cycle %0d: observed %0d expected %0d", tag, cycle, got, want);
    end
  endtask

  function automatic int dotProduct(input int r, input int c);
    int s = 0;
    for (int k = 0; k < 4; k++) s += ref_a[r*4+k] * ref_b[k*4+c];
    return s;
  endfunction

  function automatic bit runActive(input int cyc);
    int n;
    n = cyc - run_start - 1;
    return (run_start >= 0) && (n >= 0) && (n <= 64);
  endfunction

  // Expected outputs for the current cycle, derived from the term number n.
  task automatic checkCycle();
    int n, ti, tj, tk, rr, rc;
    bit act, exp_valid, exp_done;
    int exp_mp, exp_mc;
    logic exp_clr;
    n       = cycle - run_start - 1;
    act     = runActive(cycle);
    exp_mp  = 0;
    exp_mc  = 0;
    exp_clr = 1'b1;
    if (act && n < 64) begin
      ti      = n / 16;
      tj      = (n / 4) % 4;
      tk      = n % 4;
      exp_mp  = ref_a[ti*4+tk];
      exp_mc  = ref_b[tk*4+tj];
      exp_clr = (tk == 0);
    end
    exp_valid = act && (n >= 4) && (n % 4 == 0);
    exp_done  = act && (n == 64);
    checkOutput("busy", {31'b0, busy}, {31'b0, act});
    checkOutput("mplier", mplier, exp_mp);
    checkOutput("mcand", mcand, exp_mc);
    checkOutput("mac_clr", {31'b0, mac_clr}, {31'b0, exp_clr});
    checkOutput("res_valid", {31'b0, res_valid}, {31'b0, exp_valid});
    checkOutput("done", {31'b0, done}, {31'b0, exp_done});
    if (exp_valid) begin
      rr = (n - 4) / 16;
      rc = ((n - 4) / 4) % 4;
      checkOutput("res_row", {30'b0, res_row}, rr);
      checkOutput("res_col", {30'b0, res_col}, rc);
      checkOutput("mac_result", acc, dotProduct(rr, rc));
    end
  endtask

  // Advance one clock: update model and reference MAC, then check the new cycle.
  task automatic applyStimulus();
    bit idle;
    int prod;
    idle = !runActive(cycle);
    prod = int'(mplier) * int'(mcand);
    acc  = mac_clr ? prod : acc + prod;
    if (!aclr) begin
      run_start = -1;
    end else begin
      if (idle && load_en) begin
        if (load_sel) ref_b[load_addr] = int'(load_data);
        else          ref_a[load_addr] = int'(load_data);
      end
      if (idle && start) run_start = cycle;
    end
    @(posedge clk);
    #1;
    cycle++;
    checkCycle();
  endtask

  task automatic loadElem(input logic sel, input int addr, input int data);
    load_en   = 1'b1;
    load_sel  = sel;
    load_addr = 4'(addr);
    load_data = 8'(data);
    applyStimulus();
    load_en   = 1'b0;
  endtask

  task automatic loadRandom();
    for (int e = 0; e < 16; e++) loadElem(1'b0, e, int'($urandom_range(255)));
    for (int e = 0; e < 16; e++) loadElem(1'b1, e, int'($urandom_range(255)));
  endtask

  task automatic runFull();
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    repeat (67) applyStimulus();
  endtask

  initial begin
    aclr = 1'b0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0;
    load_data = '0; start = 1'b0;
    repeat (2) applyStimulus();
    checkOutput("reset_res_row", {30'b0, res_row}, 0);
    checkOutput("reset_res_col", {30'b0, res_col}, 0);
    aclr = 1'b1;
    applyStimulus();

    // Identity A, B = 4r+c+1: C must equal B.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        loadElem(1'b0, r*4+c, (r == c) ? 1 : 0);
        loadElem(1'b1, r*4+c, 4*r+c+1);
      end
    runFull();

    // Extreme operands pass through unmodified.
    for (int e = 0; e < 16; e++) begin
      loadElem(1'b0, e, -128);
      loadElem(1'b1, e, 127);
    end
    runFull();

    // Random data; start pulses and a load during the run are ignored,
    // start right after DRAIN is accepted.
    loadRandom();
    start = 1'b1;
    applyStimulus();
    for (int c = 1; c <= 66; c++) begin
      start     = (c == 10) || (c == 65) || (c == 66);
      load_en   = (c == 30);
      load_sel  = 1'b0;
      load_addr = 4'd0;
      load_data = 8'h55;
      applyStimulus();
    end
    start   = 1'b0;
    load_en = 1'b0;
    repeat (67) applyStimulus();

    // Reset in the middle of a run aborts it silently.
    start = 1'b1;
    applyStimulus();
    start = 1'b0;
    for (int c = 1; c < 40; c++) applyStimulus();
    aclr = 1'b0;
    applyStimulus();
    aclr = 1'b1;
    checkOutput("abort_res_row", {30'b0, res_row}, 0);
    checkOutput("abort_res_col", {30'b0, res_col}, 0);
    repeat (3) applyStimulus();
    loadRandom();
    runFull();

    // Write and start in the same cycle: the run uses the new B[0][0].
    load_en = 1'b1; load_sel = 1'b1; load_addr = 4'd0; load_data = 8'sd7;
    start = 1'b1;
    applyStimulus();
    load_en = 1'b0;
    start   = 1'b0;
    checkOutput("first_mcand_fwd", mcand, 7);
    repeat (67) applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
